// File: rtl/mandel_pkg.sv
// Shared types and fixed-point constants for the escape-time engine.
package mandel_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_SQUARE = 3'd1,
    ST_ACCUM  = 3'd2,
    ST_STEP   = 3'd3,
    ST_RESULT = 3'd4
  } state_e;

  typedef enum logic {
    MODE_MANDEL = 1'b0,
    MODE_JULIA  = 1'b1
  } mode_e;

  // Constants are built wide and sliced by the user to the width it needs.
  function automatic logic [127:0] esc_threshold(input int frac);
    return 128'd4 << (2 * frac);
  endfunction

  function automatic logic [127:0] three_sixteenths(input int frac);
    return 128'd3 << (frac - 4);
  endfunction

  function automatic logic [127:0] fifteen_sixteenths(input int frac);
    return 128'd15 << (frac - 4);
  endfunction

endpackage

// File: rtl/mandel_complex_square.sv
// Two-stage squaring datapath: products of z, then re2/im2/2*re*im and |z|^2.
module mandel_complex_square
  import mandel_pkg::*;
#(
  parameter int WORD_LENGTH = 32
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            en_i,
  input  logic signed [WORD_LENGTH-1:0]   re_i,
  input  logic signed [WORD_LENGTH-1:0]   im_i,
  output logic signed [2*WORD_LENGTH-1:0] re2_o,
  output logic signed [2*WORD_LENGTH-1:0] im2_o,
  output logic signed [2*WORD_LENGTH:0]   cross_o,
  output logic [2*WORD_LENGTH:0]          mag_o
);

  localparam int W2 = 2 * WORD_LENGTH;

  logic signed [W2-1:0] re_x_s, im_x_s;
  logic signed [W2-1:0] pre2_q, pim2_q, pcross_q;
  logic                 s1_vld_q;
  logic signed [W2-1:0] re2_q, im2_q;
  logic signed [W2:0]   cross_q;
  logic [W2:0]          mag_q;

  assign re_x_s = $signed({{WORD_LENGTH{re_i[WORD_LENGTH-1]}}, re_i});
  assign im_x_s = $signed({{WORD_LENGTH{im_i[WORD_LENGTH-1]}}, im_i});

  // Squares are non-negative, so the magnitude sum cannot overflow W2+1 bits.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      s1_vld_q <= 1'b0;
      pre2_q   <= '0;
      pim2_q   <= '0;
      pcross_q <= '0;
      re2_q    <= '0;
      im2_q    <= '0;
      cross_q  <= '0;
      mag_q    <= '0;
    end else begin
      s1_vld_q <= en_i;
      if (en_i) begin
        pre2_q   <= re_x_s * re_x_s;
        pim2_q   <= im_x_s * im_x_s;
        pcross_q <= re_x_s * im_x_s;
      end
      if (s1_vld_q) begin
        re2_q   <= pre2_q;
        im2_q   <= pim2_q;
        cross_q <= {pcross_q, 1'b0};
        mag_q   <= {1'b0, pre2_q} + {1'b0, pim2_q};
      end
    end
  end

  assign re2_o   = re2_q;
  assign im2_o   = im2_q;
  assign cross_o = cross_q;
  assign mag_o   = mag_q;

endmodule

// File: rtl/mandel_depth_engine.sv
// Escape-time engine (Mandelbrot/Julia) for one pixel per job.
// Optional interior short-cut enabled by defining MANDEL_INTERIOR_SKIP_EN.
module mandel_depth_engine
  import mandel_pkg::*;
#(
  parameter int WORD_LENGTH = 32,
  parameter int FRAC        = 28,
  parameter int ITER_W      = 10,
  parameter int TAG_W       = 19
) (
  input  logic                   sysclk,
  input  logic                   reset,
  input  logic                   in_valid,
  output logic                   in_ready,
  input  logic [WORD_LENGTH-1:0] in_re_c,
  input  logic [WORD_LENGTH-1:0] in_im_c,
  input  logic [TAG_W-1:0]       in_tag,
  input  logic [ITER_W-1:0]      max_iter,
  input  logic                   mode,
  input  logic [WORD_LENGTH-1:0] julia_re,
  input  logic [WORD_LENGTH-1:0] julia_im,
  output logic                   out_valid,
  input  logic                   out_ready,
  output logic [ITER_W-1:0]      out_depth,
  output logic                   out_escaped,
  output logic [TAG_W-1:0]       out_tag,
  output logic                   busy
);

  localparam int W  = WORD_LENGTH;
  localparam int W2 = 2 * WORD_LENGTH;
  localparam logic [127:0] ESC_FULL = esc_threshold(FRAC);
  localparam logic [W2:0]  ESC      = ESC_FULL[W2:0];

  state_e                 state_q, state_d;
  mode_e                  mode_q, mode_d;
  logic signed [W-1:0]    zre_q, zre_d, zim_q, zim_d;
  logic signed [W-1:0]    cre_q, cre_d, cim_q, cim_d;
  logic [TAG_W-1:0]       tag_q, tag_d;
  logic [ITER_W-1:0]      max_q, max_d, depth_q, depth_d, depth_inc_s;
  logic                   esc_q, esc_d;

  logic signed [W2-1:0]   re2_s, im2_s, re2_sh_s, im2_sh_s;
  logic signed [W2:0]     cross_s, cross_sh_s;
  logic [W2:0]            mag_s;
  logic                   skip_s;
  logic                   unused_s;

  mandel_complex_square #(.WORD_LENGTH(WORD_LENGTH)) u_square (
    .clk_i   (sysclk),
    .reset_i (reset),
    .en_i    (state_q == ST_SQUARE),
    .re_i    (zre_q),
    .im_i    (zim_q),
    .re2_o   (re2_s),
    .im2_o   (im2_s),
    .cross_o (cross_s),
    .mag_o   (mag_s)
  );

  assign re2_sh_s    = re2_s >>> FRAC;
  assign im2_sh_s    = im2_s >>> FRAC;
  assign cross_sh_s  = cross_s >>> FRAC;
  assign depth_inc_s = depth_q + ITER_W'(1);

`ifdef MANDEL_INTERIOR_SKIP_EN
  localparam int CW = W2 + 2;
  localparam logic [127:0]         T3_FULL  = three_sixteenths(FRAC);
  localparam logic [127:0]         T15_FULL = fifteen_sixteenths(FRAC);
  localparam logic signed [CW-1:0] T3       = T3_FULL[CW-1:0];
  localparam logic signed [CW-1:0] T15      = T15_FULL[CW-1:0];

  logic signed [CW-1:0] re2p_s, im2p_s, cre_x_s, bulb1_s, bulb2_s;

  // Evaluated when the products are those of z=c, i.e. the second pass.
  assign re2p_s  = {{2{re2_sh_s[W2-1]}}, re2_sh_s};
  assign im2p_s  = {{2{im2_sh_s[W2-1]}}, im2_sh_s};
  assign cre_x_s = {{(CW-W){cre_q[W-1]}}, cre_q};
  assign bulb1_s = re2p_s + (cre_x_s >>> 1) + im2p_s;
  assign bulb2_s = re2p_s + (cre_x_s <<< 1) + im2p_s;
  assign skip_s  = (mode_q == MODE_MANDEL) && (depth_q == ITER_W'(1)) &&
                   (max_q > ITER_W'(1)) && ((bulb1_s < T3) || (bulb2_s < -T15));
  assign unused_s = ^{cross_sh_s[W2:W]};
`else
  assign skip_s   = 1'b0;
  assign unused_s = ^{cross_sh_s[W2:W], re2_sh_s[W2-1:W], im2_sh_s[W2-1:W]};
`endif

  always_ff @(posedge sysclk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      mode_q  <= MODE_MANDEL;
      zre_q   <= '0;
      zim_q   <= '0;
      cre_q   <= '0;
      cim_q   <= '0;
      tag_q   <= '0;
      max_q   <= '0;
      depth_q <= '0;
      esc_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      mode_q  <= mode_d;
      zre_q   <= zre_d;
      zim_q   <= zim_d;
      cre_q   <= cre_d;
      cim_q   <= cim_d;
      tag_q   <= tag_d;
      max_q   <= max_d;
      depth_q <= depth_d;
      esc_q   <= esc_d;
    end
  end

  always_comb begin
    state_d = state_q;
    mode_d  = mode_q;
    zre_d   = zre_q;
    zim_d   = zim_q;
    cre_d   = cre_q;
    cim_d   = cim_q;
    tag_d   = tag_q;
    max_d   = max_q;
    depth_d = depth_q;
    esc_d   = esc_q;
    case (state_q)
      ST_IDLE: begin
        if (in_valid) begin
          tag_d   = in_tag;
          max_d   = max_iter;
          mode_d  = mode_e'(mode);
          depth_d = '0;
          esc_d   = 1'b0;
          if (mode == MODE_JULIA) begin
            zre_d = in_re_c;
            zim_d = in_im_c;
            cre_d = julia_re;
            cim_d = julia_im;
          end else begin
            zre_d = '0;
            zim_d = '0;
            cre_d = in_re_c;
            cim_d = in_im_c;
          end
          state_d = (max_iter == '0) ? ST_RESULT : ST_SQUARE;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SQUARE: state_d = ST_ACCUM;
      ST_ACCUM:  state_d = ST_STEP;
      ST_STEP: begin
        if (mag_s > ESC) begin
          esc_d   = 1'b1;
          state_d = ST_RESULT;
        end else if (skip_s) begin
          depth_d = max_q;
          state_d = ST_RESULT;
        end else begin
          // Wrapping truncation: only the low W bits of each term matter.
          zre_d   = re2_sh_s[W-1:0] - im2_sh_s[W-1:0] + cre_q;
          zim_d   = cross_sh_s[W-1:0] + cim_q;
          depth_d = depth_inc_s;
          state_d = (depth_inc_s == max_q) ? ST_RESULT : ST_SQUARE;
        end
      end
      ST_RESULT: begin
        if (out_ready) begin
          state_d = ST_IDLE;
        end else begin
          state_d = ST_RESULT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  assign in_ready    = (state_q == ST_IDLE);
  assign busy        = (state_q != ST_IDLE);
  assign out_valid   = (state_q == ST_RESULT);
  assign out_depth   = depth_q;
  assign out_escaped = esc_q;
  assign out_tag     = tag_q;

endmodule

// File: tb/tb_mandel_depth_engine.sv
// Directed bench for mandel_depth_engine; expected latencies follow the
// MANDEL_INTERIOR_SKIP_EN build setting.
module tb_mandel_depth_engine;

  localparam int W  = 32;
  localparam int IW = 10;
  localparam int TW = 19;

  localparam logic [W-1:0] ZERO  = 32'h0000_0000;
  localparam logic [W-1:0] ONE   = 32'h1000_0000;
  localparam logic [W-1:0] ONE5  = 32'h1800_0000;
  localparam logic [W-1:0] TWO   = 32'h2000_0000;
  localparam logic [W-1:0] HALF  = 32'h0800_0000;
  localparam logic [W-1:0] M_ONE = 32'hF000_0000;
  localparam logic [W-1:0] M_TWO = 32'hE000_0000;

  logic          sysclk = 1'b0;
  logic          reset;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  in_re_c, in_im_c, julia_re, julia_im;
  logic [TW-1:0] in_tag;
  logic [IW-1:0] max_iter;
  logic          mode;
  logic          out_valid;
  logic          out_ready;
  logic [IW-1:0] out_depth;
  logic          out_escaped;
  logic [TW-1:0] out_tag;
  logic          busy;

  int n_checks = 0;
  int n_errors = 0;
  int lat_zero, lat_m1;

  mandel_depth_engine #(.WORD_LENGTH(32), .FRAC(28), .ITER_W(10), .TAG_W(19)) dut (
    .sysclk      (sysclk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .in_re_c     (in_re_c),
    .in_im_c     (in_im_c),
    .in_tag      (in_tag),
    .max_iter    (max_iter),
    .mode        (mode),
    .julia_re    (julia_re),
    .julia_im    (julia_im),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_depth   (out_depth),
    .out_escaped (out_escaped),
    .out_tag     (out_tag),
    .busy        (busy)
  );

  always #5 sysclk = ~sysclk;

  task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: observed %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Present one job for exactly the accept edge, then scramble the inputs.
  task automatic offer(input logic md, input logic [W-1:0] re, input logic [W-1:0] im,
                       input logic [W-1:0] jre, input logic [W-1:0] jim,
                       input logic [IW-1:0] mi, input logic [TW-1:0] tg);
    in_re_c  = re;
    in_im_c  = im;
    julia_re = jre;
    julia_im = jim;
    max_iter = mi;
    mode     = md;
    in_tag   = tg;
    in_valid = 1'b1;
    @(posedge sysclk);
    #1;
    in_valid = 1'b0;
    in_re_c  = 32'h7FFF_FFFF;
    in_im_c  = 32'h4321_0000;
    julia_re = 32'h1234_5678;
    julia_im = 32'h0F0F_0F0F;
    max_iter = 10'd3;
    mode     = ~md;
    in_tag   = '1;
  endtask

  task automatic wait_result(output int lat);
    int cnt;
    cnt = 0;
    while (out_valid !== 1'b1 && cnt < 300) begin
      @(posedge sysclk);
      #1;
      cnt++;
    end
    lat = cnt + 1;
  endtask

  task automatic run_job(input string nm, input logic md,
                         input logic [W-1:0] re, input logic [W-1:0] im,
                         input logic [W-1:0] jre, input logic [W-1:0] jim,
                         input logic [IW-1:0] mi, input logic [TW-1:0] tg,
                         input logic [IW-1:0] e_depth, input logic e_esc,
                         input int e_lat, input logic do_release);
    int lat;
    check_eq({nm, ".in_ready"}, 64'(in_ready), 64'd1);
    offer(md, re, im, jre, jim, mi, tg);
    wait_result(lat);
    check_eq({nm, ".latency"}, 64'(lat), 64'(e_lat));
    check_eq({nm, ".depth"}, 64'(out_depth), 64'(e_depth));
    check_eq({nm, ".escaped"}, 64'(out_escaped), 64'(e_esc));
    check_eq({nm, ".tag"}, 64'(out_tag), 64'(tg));
    if (do_release) begin
      out_ready = 1'b1;
      @(posedge sysclk);
      #1;
      out_ready = 1'b0;
      check_eq({nm, ".idle_after"}, 64'({in_ready, out_valid}), 64'd2);
    end
  endtask

  initial begin
    int seen;
`ifdef MANDEL_INTERIOR_SKIP_EN
    lat_zero = 7;
    lat_m1   = 7;
`else
    lat_zero = 16;
    lat_m1   = 61;
`endif
    reset     = 1'b1;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    in_re_c   = '0;
    in_im_c   = '0;
    julia_re  = '0;
    julia_im  = '0;
    max_iter  = '0;
    mode      = 1'b0;
    in_tag    = '0;
    repeat (3) @(posedge sysclk);
    #1;
    reset = 1'b0;

    check_eq("rst.out_valid", 64'(out_valid), 64'd0);
    check_eq("rst.depth", 64'(out_depth), 64'd0);
    check_eq("rst.escaped", 64'(out_escaped), 64'd0);
    check_eq("rst.tag", 64'(out_tag), 64'd0);
    check_eq("rst.busy", 64'(busy), 64'd0);
    check_eq("rst.in_ready", 64'(in_ready), 64'd1);

    run_job("m_c2",    1'b0, TWO,   ZERO, ZERO, ZERO, 10'd10, 19'h00101, 10'd2,  1'b1, 10,       1'b1);
    run_job("m_c0",    1'b0, ZERO,  ZERO, ZERO, ZERO, 10'd5,  19'h00202, 10'd5,  1'b0, lat_zero, 1'b1);
    run_job("m_cm1",   1'b0, M_ONE, ZERO, ZERO, ZERO, 10'd20, 19'h00303, 10'd20, 1'b0, lat_m1,   1'b1);
    run_job("m_cm2",   1'b0, M_TWO, ZERO, ZERO, ZERO, 10'd6,  19'h00404, 10'd6,  1'b0, 19,       1'b1);
    run_job("m_half",  1'b0, HALF,  HALF, ZERO, ZERO, 10'd20, 19'h00505, 10'd5,  1'b1, 19,       1'b1);
    run_job("j_one",   1'b1, ONE,   ZERO, ZERO, ZERO, 10'd8,  19'h00606, 10'd8,  1'b0, 25,       1'b1);
    run_job("j_one5",  1'b1, ONE5,  ZERO, ZERO, ZERO, 10'd8,  19'h00707, 10'd1,  1'b1, 7,        1'b1);
    run_job("max0",    1'b0, TWO,   ONE,  ZERO, ZERO, 10'd0,  19'h5A5A5, 10'd0,  1'b0, 1,        1'b1);

    // Back-pressure: result must stay frozen while out_ready is low.
    run_job("hold", 1'b0, TWO, ZERO, ZERO, ZERO, 10'd10, 19'h12345, 10'd2, 1'b1, 10, 1'b0);
    for (int i = 0; i < 20; i++) begin
      @(posedge sysclk);
      #1;
      check_eq("hold.valid", 64'(out_valid), 64'd1);
      check_eq("hold.depth", 64'(out_depth), 64'd2);
      check_eq("hold.tag", 64'(out_tag), 64'h12345);
      check_eq("hold.in_ready", 64'(in_ready), 64'd0);
    end
    out_ready = 1'b1;
    @(posedge sysclk);
    #1;
    out_ready = 1'b0;
    check_eq("hold.released", 64'({in_ready, out_valid}), 64'd2);

    // Reset in the middle of a job drops it.
    offer(1'b0, M_ONE, ZERO, ZERO, ZERO, 10'd20, 19'h0BEEF);
    repeat (3) @(posedge sysclk);
    #1;
    check_eq("rstmid.busy_before", 64'(busy), 64'd1);
    reset = 1'b1;
    @(posedge sysclk);
    #1;
    reset = 1'b0;
    check_eq("rstmid.in_ready", 64'(in_ready), 64'd1);
    check_eq("rstmid.busy", 64'(busy), 64'd0);
    seen = 0;
    for (int i = 0; i < 80; i++) begin
      if (out_valid === 1'b1) seen++;
      @(posedge sysclk);
      #1;
    end
    check_eq("rstmid.no_output", 64'(seen), 64'd0);

    run_job("after_rst", 1'b0, TWO, ZERO, ZERO, ZERO, 10'd10, 19'h00808, 10'd2, 1'b1, 10, 1'b1);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/mandel_depth_engine.md
# mandel_depth_engine

Parametrised escape-time engine that iterates z ← z² + c in signed fixed point for one pixel at a time and reports the escape depth. Successor to the fixed-width depth calculator: generic word/fraction/iteration widths, valid/ready handshakes on both sides, tag passthrough and a Mandelbrot/Julia mode. Sits between the pixel-coordinate generator and the colour mapper; several instances run in parallel behind a dispatcher.

## Interface
- WORD_LENGTH, 32: total bits of every fixed-point value (signed, even, 16..48)
- FRAC, 28: fractional bits (FRAC ≤ WORD_LENGTH-3)
- ITER_W, 10: width of max_iter and out_depth
- TAG_W, 19: width of the opaque pixel tag ({y,x})

- sysclk  in  1  clock
- reset  in  1  synchronous, active-high
- in_valid  in  1  job offered
- in_ready  out  1  engine can accept (high only in IDLE)
- in_re_c / in_im_c  in  WORD_LENGTH  pixel coordinate
- in_tag  in  TAG_W  carried to out_tag
- max_iter  in  ITER_W  iteration limit, sampled at accept
- mode  in  1  0 = Mandelbrot (z0=0, c=pixel), 1 = Julia (z0=pixel, c=julia const); sampled at accept
- julia_re / julia_im  in  WORD_LENGTH  Julia constant, sampled at accept
- out_valid  out  1  result available
- out_ready  in  1  consumer takes result
- out_depth  out  ITER_W  escape depth
- out_escaped  out  1  1 = escaped, 0 = hit limit/interior
- out_tag  out  TAG_W  tag of the job
- busy  out  1  high in any state other than IDLE

## Operation
- States: IDLE, SQUARE, ACCUM, STEP, RESULT.
- IDLE: in_ready=1; on in_valid, latch c, z0, tag, max_iter, mode; depth←0; go SQUARE. If latched max_iter=0 go straight to RESULT with depth 0, escaped 0.
- SQUARE: register full 2·WORD_LENGTH signed products re², im², re·im.
- ACCUM: register re2, im2, cross = 2·re·im, and mag = re2+im2 (2·WORD_LENGTH+1 bits, no overflow).
- STEP: if mag > 4·2^(2·FRAC) → RESULT, escaped=1, depth unchanged. Else z.re ← (re2>>>FRAC)−(im2>>>FRAC)+c.re, z.im ← (cross>>>FRAC)+c.im, truncated to WORD_LENGTH (wrap, no saturation); depth+1; if new depth = max_iter → RESULT, escaped=0; else SQUARE.
- Escape test uses strict >; |z|²=4 exactly does not escape.
- RESULT: out_valid=1, outputs stable until out_ready; on out_valid&&out_ready go IDLE. No skid buffer: one bubble cycle between jobs.
- Inputs other than in_valid/out_ready ignored outside IDLE; max_iter/julia changes mid-job have no effect.

## Timing
- Reset: state IDLE; out_valid 0, out_depth 0, out_escaped 0, out_tag 0, busy 0; in_ready 1 from first cycle after reset release.
- Accept edge = cycle 0. Escape at iteration k: out_valid at cycle 3k+4. Limit reached: cycle 3·max_iter+1. max_iter=0: cycle 1.
- Reset asserted mid-job: job dropped, no output produced, IDLE next cycle.
- out_ready held low: RESULT held indefinitely, in_ready stays 0.

## Configuration
- MANDEL_INTERIOR_SKIP_EN defined: in Mandelbrot mode only, at STEP of iteration 1 (z=c, non-escaped), if re2'+re/2+im2' < 3/16 or re2'+2re+im2' < −15/16 (re2', im2' = products >>>FRAC, re=c.re) → RESULT, depth=max_iter, escaped=0 (latency 7). Skipped if max_iter ≤ 1.
- Undefined: no interior test; every point iterates to escape or limit. Julia mode identical in both builds.

## Structure
- Package mandel_pkg: state enum, mode enum, fixed-point constants (escape threshold, 3/16, 15/16 as functions of FRAC/WORD_LENGTH).
- Sub-module mandel_complex_square: SQUARE+ACCUM datapath (z in → re2, im2, cross, mag out, 2-cycle latency, enable input); FSM and STEP arithmetic in top.

## Test plan
- Mandelbrot, c=(2.0,0), max_iter=10 → out_depth=2, escaped=1, out_valid 10 cycles after accept.
- c=(0,0), max_iter=5, skip undefined → depth 5, escaped 0, latency 16; skip defined → depth 5, escaped 0, latency 7.
- c=(−1.0,0), max_iter=20 → depth 20, escaped 0 (skip build: bulb test hits, latency 7).
- Julia, julia=(0,0), pixel=(1.0,0.0), max_iter=8 → |z|²=1 forever, depth 8, escaped 0; pixel=(1.5,0) → depth 1, escaped 1.
- max_iter=0 → out_valid at cycle 1, depth 0, escaped 0; tag 0x5A5A5 echoed.
- Hold out_ready low 20 cycles then pulse; assert reset mid-iteration on a second job → first result stable throughout, second job produces no out_valid, in_ready high cycle after reset.
